m_serial_adder32: RTL

M_SERIAL_ADDER32 -- requirements
Module: m_serial_adder32

---
 rtl/m_serial_adder32.sv | 138 +++++++++++++
 1 files changed

// File: rtl/m_serial_adder32.sv
// Nibble-serial 32-bit adder/subtractor built around one reused
// 4-bit carry-lookahead slice, with valid/ready on both sides.
module m_adder4 (
  input  logic [3:0] i_a_4,
  input  logic [3:0] i_b_4,
  input  logic       i_c_1,
  output logic [3:0] o_s_4,
  output logic       o_c_1
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = i_a_4 & i_b_4;
    p    = i_a_4 ^ i_b_4;
    c[0] = i_c_1;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    o_s_4 = p ^ c[3:0];
    o_c_1 = c[4];
  end

endmodule

module m_serial_adder32 (
  input  logic        i_clk_1,
  input  logic        i_rst_1,
  input  logic        i_valid_1,
  output logic        o_ready_1,
  input  logic        i_sub_1,
  input  logic [31:0] i_operandA_32,
  input  logic [31:0] i_operandB_32,
  output logic        o_valid_1,
  input  logic        i_ready_1,
  output logic [31:0] o_result_32,
  output logic        o_cOut_1,
  output logic        o_overflow_1,
  output logic        o_zero_1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;

  logic [4:0]  bit_base;
  logic [3:0]  slice_sum;
  logic        slice_cout;

  assign bit_base = {cnt_q, 2'b00};

  m_adder4 u_adder4 (
    .i_a_4 (a_q[bit_base +: 4]),
    .i_b_4 (b_q[bit_base +: 4]),
    .i_c_1 (carry_q),
    .o_s_4 (slice_sum),
    .o_c_1 (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid_1) begin
          a_d     = i_operandA_32;
          b_d     = i_operandB_32 ^ {32{i_sub_1}};
          carry_d = i_sub_1;
          cnt_d   = 3'd0;
          res_d   = 32'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[bit_base +: 4] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        if (i_ready_1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_1) begin
    if (i_rst_1) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      carry_q <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Everything is gated so nothing leaks out during reset or mid-run.
  always_comb begin
    o_ready_1    = (state_q == IDLE) && !i_rst_1;
    o_valid_1    = (state_q == DONE) && !i_rst_1;
    o_result_32  = o_valid_1 ? res_q : 32'd0;
    o_cOut_1     = o_valid_1 & carry_q;
    o_overflow_1 = o_valid_1 & (a_q[31] == b_q[31])
                 & (res_q[31] != a_q[31]);
    o_zero_1     = o_valid_1 & (res_q == 32'd0);
  end

endmodule
